// File: rtl/mem_bus_arbiter_if.sv
// -----------------------------------------------------------------------------
// mem_bus_arbiter_if
//   Bundle of every signal between the two-master arbiter, its two masters and
//   the 8-bit memory/IO map.
//
//   Master 0 / master 1 request side (driven by the masters):
//     mN_req    level request
//     mN_we     1 = write, 0 = read
//     mN_lock   keep ownership for the next request (wins ties only)
//     mN_addr   8-bit address
//     mN_wdata  8-bit write data
//   Master 0 / master 1 response side (driven by the arbiter):
//     mN_ack    one-cycle completion pulse
//     mN_rdata  read data, valid with mN_ack and held until the next read
//   Memory side:
//     mem_addr, mem_wdata, mem_we  driven by the arbiter
//     mem_rdata                    driven by the memory/IO map
//   Status:
//     grant  one-hot owner during ACCESS/RESP, 2'b00 in IDLE
//     busy   high whenever the arbiter is not IDLE
//
//   Modports:
//     slave   the arbiter's view
//     master  the environment's view (masters plus memory map)
// -----------------------------------------------------------------------------
interface mem_bus_arbiter_if;

  logic       m0_req;
  logic       m0_we;
  logic       m0_lock;
  logic [7:0] m0_addr;
  logic [7:0] m0_wdata;
  logic       m0_ack;
  logic [7:0] m0_rdata;

  logic       m1_req;
  logic       m1_we;
  logic       m1_lock;
  logic [7:0] m1_addr;
  logic [7:0] m1_wdata;
  logic       m1_ack;
  logic [7:0] m1_rdata;

  logic [7:0] mem_addr;
  logic [7:0] mem_wdata;
  logic       mem_we;
  logic [7:0] mem_rdata;

  logic [1:0] grant;
  logic       busy;

  modport slave (
    input  m0_req, m0_we, m0_lock, m0_addr, m0_wdata,
    output m0_ack, m0_rdata,
    input  m1_req, m1_we, m1_lock, m1_addr, m1_wdata,
    output m1_ack, m1_rdata,
    output mem_addr, mem_wdata, mem_we,
    input  mem_rdata,
    output grant, busy
  );

  modport master (
    output m0_req, m0_we, m0_lock, m0_addr, m0_wdata,
    input  m0_ack, m0_rdata,
    output m1_req, m1_we, m1_lock, m1_addr, m1_wdata,
    input  m1_ack, m1_rdata,
    input  mem_addr, mem_wdata, mem_we,
    output mem_rdata,
    input  grant, busy
  );

endinterface : mem_bus_arbiter_if

// File: rtl/mem_bus_arbiter.sv
// -----------------------------------------------------------------------------
// mem_bus_arbiter
//   Two-master arbiter and sequencer for the 8-bit memory/IO bus. Exactly one
//   transaction owns the bus at a time, and each transaction makes exactly one
//   clean access, which matters for IO registers with read side effects.
//
//   Arbitration is round-robin between master 0 (CPU) and master 1 (boot
//   loader / DMA). A master that completes with its lock input high becomes
//   the lock owner and wins the next tie.
//
//   Transaction flow:
//     IDLE   -> pick a winner, latch its addr/we/wdata, drive them to memory
//     ACCESS -> hold the latched access; writes last one cycle, reads RD_WAIT
//               cycles, with read data sampled on the last one
//     RESP   -> one-cycle ack to the owner, update lock and fairness state
//
//   Parameters:
//     RD_WAIT  cycles a read address is held before mem_rdata is sampled (1..4)
//
//   Ports:
//     clk    system clock, rising edge
//     reset  asynchronous, active-high reset
//     bus    mem_bus_arbiter_if.slave (masters, memory map, grant, busy)
// -----------------------------------------------------------------------------
module mem_bus_arbiter #(
  parameter int RD_WAIT = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  mem_bus_arbiter_if.slave      bus
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_RESP   = 2'd2
  } state_t;

  // Counter reload for reads: the address is held RD_WAIT cycles in total,
  // the last of which is the one where the counter reads zero.
  localparam logic [1:0] RD_LOAD = 2'(RD_WAIT - 1);

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  state_t     r_state;
  logic       r_owner;       // 0 = master 0, 1 = master 1 (valid outside IDLE)
  logic       r_we;          // latched direction of the current transaction
  logic [1:0] r_cnt;         // ACCESS wait counter
  logic       r_last;        // master served most recently
  logic       r_lock_valid;  // a lock owner exists
  logic       r_lock_owner;  // which master holds the lock
  logic [1:0] r_grant;

  logic [7:0] r_mem_addr;
  logic [7:0] r_mem_wdata;
  logic       r_mem_we;

  logic       r_m0_ack;
  logic       r_m1_ack;
  logic [7:0] r_m0_rdata;
  logic [7:0] r_m1_rdata;

  // ---------------------------------------------------------------------------
  // Winner selection (only consumed in IDLE)
  // ---------------------------------------------------------------------------
  logic       w_sel_valid;
  logic       w_sel;
  logic       w_sel_we;
  logic [7:0] w_sel_addr;
  logic [7:0] w_sel_wdata;
  logic       w_owner_lock;
  logic       w_lock_owner_req;

  // NOTE: every signal assigned in always_comb gets a default first, so no
  // path through the block leaves it unassigned and no latch is inferred.
  always_comb begin
    w_sel_valid = bus.m0_req | bus.m1_req;
    w_sel       = 1'b0;
    if (bus.m0_req && bus.m1_req) begin
      // On a tie the lock owner wins; both are requesting here, so the owner
      // is by definition still requesting. Otherwise alternate.
      if (r_lock_valid) begin
        w_sel = r_lock_owner;
      end else begin
        w_sel = ~r_last;
      end
    end else if (bus.m1_req) begin
      w_sel = 1'b1;
    end
  end

  always_comb begin
    w_sel_we    = bus.m0_we;
    w_sel_addr  = bus.m0_addr;
    w_sel_wdata = bus.m0_wdata;
    if (w_sel) begin
      w_sel_we    = bus.m1_we;
      w_sel_addr  = bus.m1_addr;
      w_sel_wdata = bus.m1_wdata;
    end
  end

  // Lock input of the master currently owning the bus, sampled in RESP.
  assign w_owner_lock     = r_owner ? bus.m1_lock : bus.m0_lock;
  // Request of the lock holder, used to drop a lock its owner has abandoned.
  assign w_lock_owner_req = r_lock_owner ? bus.m1_req : bus.m0_req;

  // ---------------------------------------------------------------------------
  // Sequencer
  // ---------------------------------------------------------------------------
  // NOTE: sequential state is written with non-blocking assignments only, so
  // every register samples the pre-edge value of every other register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state      <= ST_IDLE;
      r_owner      <= 1'b0;
      r_we         <= 1'b0;
      r_cnt        <= 2'd0;
      r_last       <= 1'b1;   // master 0 wins the first tie
      r_lock_valid <= 1'b0;
      r_lock_owner <= 1'b0;
      r_grant      <= 2'b00;
      r_mem_addr   <= 8'h00;
      r_mem_wdata  <= 8'h00;
      r_mem_we     <= 1'b0;
      r_m0_ack     <= 1'b0;
      r_m1_ack     <= 1'b0;
      r_m0_rdata   <= 8'h00;
      r_m1_rdata   <= 8'h00;
    end else begin
      unique case (r_state)
        ST_IDLE: begin
          // A lock whose owner is no longer asking for the bus is released.
          if (r_lock_valid && !w_lock_owner_req) begin
            r_lock_valid <= 1'b0;
          end
          if (w_sel_valid) begin
            // The memory-side registers double as the latched request, so
            // later changes on the master inputs cannot reach the bus.
            r_owner     <= w_sel;
            r_grant     <= w_sel ? 2'b10 : 2'b01;
            r_we        <= w_sel_we;
            r_mem_addr  <= w_sel_addr;
            r_mem_wdata <= w_sel_wdata;
            r_mem_we    <= w_sel_we;
            r_cnt       <= w_sel_we ? 2'd0 : RD_LOAD;
            r_state     <= ST_ACCESS;
          end
        end

        ST_ACCESS: begin
          if (r_cnt != 2'd0) begin
            r_cnt <= r_cnt - 2'd1;
          end else begin
            // Dropping mem_we here bounds a write strobe to one cycle.
            r_mem_we <= 1'b0;
            if (!r_we) begin
              if (r_owner) begin
                r_m1_rdata <= bus.mem_rdata;
              end else begin
                r_m0_rdata <= bus.mem_rdata;
              end
            end
            r_m0_ack <= ~r_owner;
            r_m1_ack <= r_owner;
            r_state  <= ST_RESP;
          end
        end

        ST_RESP: begin
          r_m0_ack     <= 1'b0;
          r_m1_ack     <= 1'b0;
          r_lock_valid <= w_owner_lock;
          r_lock_owner <= r_owner;
          r_last       <= r_owner;
          r_grant      <= 2'b00;
          r_state      <= ST_IDLE;
        end

        default: begin
          r_mem_we <= 1'b0;
          r_m0_ack <= 1'b0;
          r_m1_ack <= 1'b0;
          r_grant  <= 2'b00;
          r_state  <= ST_IDLE;
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs (all straight from registers)
  // ---------------------------------------------------------------------------
  assign bus.mem_addr  = r_mem_addr;
  assign bus.mem_wdata = r_mem_wdata;
  assign bus.mem_we    = r_mem_we;
  assign bus.m0_ack    = r_m0_ack;
  assign bus.m1_ack    = r_m1_ack;
  assign bus.m0_rdata  = r_m0_rdata;
  assign bus.m1_rdata  = r_m1_rdata;
  assign bus.grant     = r_grant;
  assign bus.busy      = (r_state != ST_IDLE);

endmodule : mem_bus_arbiter

// File: tb/tb_mem_bus_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mem_bus_arbiter
//   Directed bench for mem_bus_arbiter. Two instances share one memory model:
//   u_dut1 with RD_WAIT=1 and u_dut3 with RD_WAIT=3. Inputs are driven 1 time
//   unit after a rising edge and outputs are sampled at the same point.
// -----------------------------------------------------------------------------
module tb_mem_bus_arbiter;

  logic clk;
  logic reset;

  mem_bus_arbiter_if bus1 ();
  mem_bus_arbiter_if bus3 ();

  mem_bus_arbiter #(.RD_WAIT(1)) u_dut1 (
    .clk   (clk),
    .reset (reset),
    .bus   (bus1)
  );

  mem_bus_arbiter #(.RD_WAIT(3)) u_dut3 (
    .clk   (clk),
    .reset (reset),
    .bus   (bus3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Shared memory model: combinational read, synchronous write.
  logic [7:0] mem_model [256];
  assign bus1.mem_rdata = mem_model[bus1.mem_addr];
  assign bus3.mem_rdata = mem_model[bus3.mem_addr];

  always @(posedge clk) begin
    if (bus1.mem_we) mem_model[bus1.mem_addr] <= bus1.mem_wdata;
    if (bus3.mem_we) mem_model[bus3.mem_addr] <= bus3.mem_wdata;
  end

  int checks   = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got=0x%0h expected=0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus1.m0_req = 0; bus1.m0_we = 0; bus1.m0_lock = 0; bus1.m0_addr = 0; bus1.m0_wdata = 0;
    bus1.m1_req = 0; bus1.m1_we = 0; bus1.m1_lock = 0; bus1.m1_addr = 0; bus1.m1_wdata = 0;
    bus3.m0_req = 0; bus3.m0_we = 0; bus3.m0_lock = 0; bus3.m0_addr = 0; bus3.m0_wdata = 0;
    bus3.m1_req = 0; bus3.m1_we = 0; bus3.m1_lock = 0; bus3.m1_addr = 0; bus3.m1_wdata = 0;
  endtask

  task automatic do_reset();
    idle_inputs();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
  endtask

  // Wait (bounded) for the next ack on u_dut1; who = -1 on timeout.
  task automatic wait_ack1(output int who);
    who = -1;
    for (int i = 0; i < 20; i++) begin
      tick();
      check("ack_exclusive", {31'd0, bus1.m0_ack & bus1.m1_ack}, 32'd0);
      if (bus1.m0_ack) begin
        who = 0;
        break;
      end
      if (bus1.m1_ack) begin
        who = 1;
        break;
      end
    end
  endtask

  initial begin
    int who;
    int exp_seq [4];

    for (int i = 0; i < 256; i++) mem_model[i] = 8'h00;
    mem_model[8'h20] = 8'h3C;

    idle_inputs();
    reset = 1'b1;
    #23;
    // ---- reset state ----
    check("rst_busy",     {31'd0, bus1.busy},   32'd0);
    check("rst_grant",    {30'd0, bus1.grant},  32'd0);
    check("rst_mem_we",   {31'd0, bus1.mem_we}, 32'd0);
    check("rst_mem_addr", {24'd0, bus1.mem_addr}, 32'd0);
    check("rst_acks",     {30'd0, bus1.m0_ack, bus1.m1_ack}, 32'd0);
    check("rst_rdata",    {16'd0, bus1.m0_rdata, bus1.m1_rdata}, 32'd0);
    tick();
    reset = 1'b0;

    // ---- M0 write 0x10 <= 0xA5 alone ----
    bus1.m0_req = 1; bus1.m0_we = 1; bus1.m0_addr = 8'h10; bus1.m0_wdata = 8'hA5;
    tick();  // accept edge
    bus1.m0_req = 0;
    check("wr_acc_mem_we",   {31'd0, bus1.mem_we},    32'd1);
    check("wr_acc_mem_addr", {24'd0, bus1.mem_addr},  32'h10);
    check("wr_acc_mem_wdata",{24'd0, bus1.mem_wdata}, 32'hA5);
    check("wr_acc_grant",    {30'd0, bus1.grant},     32'b01);
    check("wr_acc_busy",     {31'd0, bus1.busy},      32'd1);
    check("wr_acc_ack",      {31'd0, bus1.m0_ack},    32'd0);
    tick();
    check("wr_resp_mem_we",  {31'd0, bus1.mem_we},    32'd0);
    check("wr_resp_ack",     {31'd0, bus1.m0_ack},    32'd1);
    check("wr_resp_m1_ack",  {31'd0, bus1.m1_ack},    32'd0);
    check("wr_resp_grant",   {30'd0, bus1.grant},     32'b01);
    tick();
    check("wr_idle_ack",     {31'd0, bus1.m0_ack},    32'd0);
    check("wr_idle_grant",   {30'd0, bus1.grant},     32'b00);
    check("wr_idle_busy",    {31'd0, bus1.busy},      32'd0);
    check("wr_mem_content",  {24'd0, mem_model[8'h10]}, 32'hA5);

    // ---- M1 read 0x20, RD_WAIT=1 ----
    bus1.m1_req = 1; bus1.m1_we = 0; bus1.m1_addr = 8'h20;
    tick();
    bus1.m1_req = 0;
    check("rd1_acc_grant",   {30'd0, bus1.grant},    32'b10);
    check("rd1_acc_mem_we",  {31'd0, bus1.mem_we},   32'd0);
    check("rd1_acc_mem_addr",{24'd0, bus1.mem_addr}, 32'h20);
    check("rd1_acc_ack",     {31'd0, bus1.m1_ack},   32'd0);
    tick();
    check("rd1_resp_ack",    {31'd0, bus1.m1_ack},   32'd1);
    check("rd1_resp_m0_ack", {31'd0, bus1.m0_ack},   32'd0);
    check("rd1_resp_rdata",  {24'd0, bus1.m1_rdata}, 32'h3C);
    check("rd1_resp_mem_we", {31'd0, bus1.mem_we},   32'd0);
    tick();
    check("rd1_rdata_held",  {24'd0, bus1.m1_rdata}, 32'h3C);
    check("rd1_idle_ack",    {31'd0, bus1.m1_ack},   32'd0);

    // ---- M1 read 0x20, RD_WAIT=3: ack in cycle 4 ----
    bus3.m1_req = 1; bus3.m1_we = 0; bus3.m1_addr = 8'h20;
    tick();
    bus3.m1_req = 0;
    for (int c = 1; c <= 3; c++) begin
      check($sformatf("rd3_c%0d_ack", c),    {31'd0, bus3.m1_ack}, 32'd0);
      check($sformatf("rd3_c%0d_mem_we", c), {31'd0, bus3.mem_we}, 32'd0);
      check($sformatf("rd3_c%0d_busy", c),   {31'd0, bus3.busy},   32'd1);
      tick();
    end
    check("rd3_c4_ack",   {31'd0, bus3.m1_ack},   32'd1);
    check("rd3_c4_rdata", {24'd0, bus3.m1_rdata}, 32'h3C);
    tick();

    // ---- address change during ACCESS is ignored (RD_WAIT=3, M0 read 0x10) ----
    bus3.m0_req = 1; bus3.m0_we = 0; bus3.m0_addr = 8'h10;
    tick();
    bus3.m0_req = 0;
    bus3.m0_addr = 8'h55;
    tick();
    check("addr_hold_c2", {24'd0, bus3.mem_addr}, 32'h10);
    tick();
    check("addr_hold_c3", {24'd0, bus3.mem_addr}, 32'h10);
    tick();
    check("addr_hold_ack",   {31'd0, bus3.m0_ack},   32'd1);
    check("addr_hold_rdata", {24'd0, bus3.m0_rdata}, 32'hA5);
    check("addr_hold_resp",  {24'd0, bus3.mem_addr}, 32'h10);
    tick();

    // ---- both masters request continuously: M0, M1, M0, M1 ----
    do_reset();
    bus1.m0_req = 1; bus1.m0_addr = 8'h10;
    bus1.m1_req = 1; bus1.m1_addr = 8'h20;
    exp_seq = '{0, 1, 0, 1};
    for (int n = 0; n < 4; n++) begin
      wait_ack1(who);
      check($sformatf("rr_owner_%0d", n), who, exp_seq[n]);
      check($sformatf("rr_grant_%0d", n), {30'd0, bus1.grant},
            (exp_seq[n] == 1) ? 32'b10 : 32'b01);
    end
    idle_inputs();
    tick();
    tick();

    // ---- M1 lock: M0 first tie, then M1 holds; drop lock -> M0 ----
    do_reset();
    bus1.m0_req = 1; bus1.m0_addr = 8'h10;
    bus1.m1_req = 1; bus1.m1_addr = 8'h20; bus1.m1_lock = 1;
    exp_seq = '{0, 1, 1, 1};
    for (int n = 0; n < 4; n++) begin
      wait_ack1(who);
      check($sformatf("lock_owner_%0d", n), who, exp_seq[n]);
    end
    // Still in the RESP cycle of the last M1 transaction: release the lock.
    bus1.m1_lock = 0;
    wait_ack1(who);
    check("lock_release_owner", who, 0);
    wait_ack1(who);
    check("lock_after_rr", who, 1);
    idle_inputs();
    tick();
    tick();

    // ---- reset in the middle of a read ACCESS (RD_WAIT=3) ----
    bus3.m0_req = 1; bus3.m0_we = 0; bus3.m0_addr = 8'h20;
    tick();
    bus3.m0_req = 0;
    tick();
    check("abort_busy_pre", {31'd0, bus3.busy}, 32'd1);
    reset = 1'b1;
    #1;
    check("abort_busy",   {31'd0, bus3.busy},   32'd0);
    check("abort_grant",  {30'd0, bus3.grant},  32'd0);
    check("abort_mem_we", {31'd0, bus3.mem_we}, 32'd0);
    check("abort_ack",    {31'd0, bus3.m0_ack}, 32'd0);
    #2;
    reset = 1'b0;
    for (int c = 0; c < 5; c++) begin
      tick();
      check($sformatf("abort_no_ack_%0d", c), {31'd0, bus3.m0_ack}, 32'd0);
    end
    bus3.m0_req = 1; bus3.m0_we = 0; bus3.m0_addr = 8'h20;
    tick();
    bus3.m0_req = 0;
    check("post_abort_grant", {30'd0, bus3.grant}, 32'b01);
    tick();
    tick();
    check("post_abort_c3_ack", {31'd0, bus3.m0_ack},   32'd0);
    tick();
    check("post_abort_ack",    {31'd0, bus3.m0_ack},   32'd1);
    check("post_abort_rdata",  {24'd0, bus3.m0_rdata}, 32'h3C);
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Global watchdog: the directed sequence is far shorter than this.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

endmodule : tb_mem_bus_arbiter

// File: doc/mem_bus_arbiter.md
Name: mem_bus_arbiter

Overview:
- Two-master arbiter and sequencer for the 8-bit memory/IO bus: address, write data, write enable and read data.
- Master 0 is the CPU; master 1 is a secondary requester, such as the UART boot loader or a DMA engine.
- Serialises accesses so that exactly one transaction drives the bus at a time. Uses round-robin fairness with an optional lock for back-to-back sequences.
- Enforces a single clean access per transaction. This matters because IO registers, such as the UART RX data register, have read side effects.

Parameters:
- RD_WAIT, 1, bus cycles a read address is held before read data is sampled (legal range 1..4).

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- m0_req  in  1  master 0 requests a transaction (level).
- m0_we  in  1  master 0: 1 = write, 0 = read.
- m0_lock  in  1  master 0 keeps ownership for its next request.
- m0_addr  in  8  master 0 address.
- m0_wdata  in  8  master 0 write data.
- m0_ack  out  1  one-cycle completion pulse to master 0.
- m0_rdata  out  8  read data for master 0, valid while m0_ack is high.
- m1_req, m1_we, m1_lock, m1_addr, m1_wdata, m1_ack, m1_rdata  same as the master 0 ports, for master 1.
- mem_addr  out  8  address to the memory/IO map.
- mem_wdata  out  8  write data to the memory/IO map.
- mem_we  out  1  write enable to the memory/IO map.
- mem_rdata  in  8  read data from the memory/IO map.
- grant  out  2  one-hot owner during ACCESS and RESP; 2'b00 in IDLE.
- busy  out  1  high whenever state != IDLE.

Behaviour:
- Reset values (asynchronous, effective immediately):
  - state = IDLE, mem_we = 0, mem_addr = 0, mem_wdata = 0.
  - m0_ack = m1_ack = 0, m0_rdata = m1_rdata = 0, grant = 0, busy = 0.
  - last_served = 1, so master 0 wins the first tie.
  - lock_owner = none, wait counter = 0.
- States: IDLE, ACCESS, RESP.
- IDLE:
  - Select a winner from the masters with req high.
  - Single requester: that master wins.
  - Both requesting: lock_owner wins if set and still requesting; otherwise the master != last_served wins.
  - On the selecting edge: latch the winner's addr, we and wdata into internal registers; set grant; load the counter.
  - Counter load: 0 for writes, RD_WAIT-1 for reads.
  - Next state is ACCESS. With no request, stay in IDLE.
- ACCESS:
  - mem_addr and mem_wdata come from the latched registers.
  - mem_we = latched we. Writes therefore assert mem_we for exactly one cycle.
  - Master inputs are ignored, so changes to a master's addr/data after acceptance have no effect.
  - Counter != 0: decrement and stay in ACCESS.
  - Counter == 0: for a read, capture mem_rdata into the granted master's rdata register; go to RESP.
- RESP:
  - mem_we = 0; mem_addr holds its value.
  - The granted master's ack = 1 for exactly this cycle; its rdata is valid and held until that master's next read completes.
  - Sample the granted master's lock: if high, lock_owner = that master, else lock_owner = none.
  - last_served = granted master. Next state is IDLE.
- Latency, request-accept edge to ack:
  - Write: ack in the 2nd cycle after acceptance.
  - Read: ack in cycle 1+RD_WAIT after acceptance.
  - Every transaction spends at least one cycle in IDLE before the next grant.
- Masters must drop req or present a new request in the cycle after ack. A req still high in IDLE is treated as a new transaction.
- A request raised during ACCESS or RESP waits; it is not lost provided req is held.
- Lock:
  - Lock only wins ties.
  - A locked master that drops req loses the lock at the next IDLE arbitration in which it is not requesting (lock_owner cleared).
- Reset asserted mid-ACCESS aborts the transaction: no ack, mem_we drops immediately, and the write may or may not have taken effect.
- The non-granted master's ack is always 0; the two acks are never high together.

Test Plan:
- M0 write addr=0x10 data=0xA5 alone -> mem_we high for exactly 1 cycle with mem_addr=0x10 and mem_wdata=0xA5; m0_ack in the 2nd cycle after accept; grant=01.
- M1 read addr=0x20, memory returns 0x3C, RD_WAIT=1 then RD_WAIT=3 -> m1_rdata=0x3C with m1_ack 2 and 4 cycles after accept respectively; mem_we stays 0.
- Both masters hold req continuously (reads) after reset -> grants alternate M0, M1, M0, M1; no two consecutive grants to the same master.
- M1 holds lock=1 with continuous req and M0 also requesting -> M1 granted on every transaction; M1 drops lock -> M0 granted next.
- Master changes addr from 0x10 to 0x55 during ACCESS -> mem_addr stays 0x10.
- Reset pulsed in the middle of a read ACCESS -> busy=0, grant=0, mem_we=0 and no ack pulse; the next M0 request completes normally.
